// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control-stage registers: bundle layout,
// bubble constant and the skid-buffer occupancy encoding.
package pipe_pkg;

    localparam int unsigned CTRL_W = 4;

    // Bit positions inside the default {RegWrite, MemWrite, ResultSrc[1:0]} bundle
    localparam int unsigned REGWRITE  = 3;
    localparam int unsigned MEMWRITE  = 2;
    localparam int unsigned RESULTSRC = 0;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic [1:0] resultSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stageState_e;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One pipeline stage for a W-bit control bundle with valid/ready handshake,
// flush-to-bubble, optional 2-entry skid buffer and a saturating stall counter.
module pipe_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int unsigned  W      = CTRL_W,
    parameter logic [W-1:0] BUBBLE = W'(CTRL_BUBBLE),
    parameter bit           SKID   = 1'b1,
    parameter int unsigned  CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         headValid;
    logic [W-1:0] headData;
    logic [CNT_W-1:0] stallCntQ;

    if (SKID) begin : gSkid
        stageState_e  stateQ;
        logic [W-1:0] mainQ;
        logic [W-1:0] skidQ;
        logic         validQ;
        logic         readyQ;
        logic         inXfer;
        logic         outXfer;

        assign inXfer  = in_valid & readyQ;
        assign outXfer = validQ & out_ready;

        // Occupancy FSM; valid and ready are registered alongside the state so
        // neither handshake output has a combinational input path.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                stateQ <= EMPTY;
                mainQ  <= BUBBLE;
                skidQ  <= BUBBLE;
                validQ <= 1'b0;
                readyQ <= 1'b1;
            end else begin
                unique case (stateQ)
                    EMPTY: begin
                        if (inXfer) begin
                            stateQ <= ONE;
                            mainQ  <= in_data;
                            validQ <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (inXfer && outXfer) begin
                            mainQ <= in_data;
                        end else if (inXfer) begin
                            stateQ <= FULL;
                            skidQ  <= in_data;
                            readyQ <= 1'b0;
                        end else if (outXfer) begin
                            stateQ <= EMPTY;
                            mainQ  <= BUBBLE;
                            validQ <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (outXfer) begin
                            stateQ <= ONE;
                            mainQ  <= skidQ;
                            skidQ  <= BUBBLE;
                            readyQ <= 1'b1;
                        end
                    end
                    default: begin
                        stateQ <= EMPTY;
                        mainQ  <= BUBBLE;
                        skidQ  <= BUBBLE;
                        validQ <= 1'b0;
                        readyQ <= 1'b1;
                    end
                endcase
            end
        end

        assign headValid = validQ;
        assign headData  = mainQ;
        assign in_ready  = readyQ;
    end else begin : gDirect
        logic [W-1:0] mainQ;
        logic         validQ;
        logic         readyInt;
        logic         inXfer;
        logic         outXfer;

        // A consumed head frees the slot in the same cycle.
        assign readyInt = ~validQ | out_ready;
        assign inXfer   = in_valid & readyInt;
        assign outXfer  = validQ & out_ready;

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                mainQ  <= BUBBLE;
                validQ <= 1'b0;
            end else if (inXfer) begin
                mainQ  <= in_data;
                validQ <= 1'b1;
            end else if (outXfer) begin
                mainQ  <= BUBBLE;
                validQ <= 1'b0;
            end
        end

        assign headValid = validQ;
        assign headData  = mainQ;
        assign in_ready  = readyInt;
    end

    // Flush leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= '0;
        end else if (headValid && !out_ready && stallCntQ != CNT_MAX) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end

    assign out_valid = headValid;
    assign out_data  = headValid ? headData : BUBBLE;
    assign stall_cnt = stallCntQ;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Drives a skid and a single-register stage with the same stimulus and checks
// both against a queue-based occupancy model.
module tb_pipe_ctrl_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       out_ready = 1'b0;

    logic       inReady1, outValid1, inReady0, outValid0;
    logic [3:0] outData1, outData0, stallCnt1, stallCnt0;

    int nChecks = 0;
    int nBad    = 0;
    bit armed   = 1'b0;

    logic [3:0] q1[$];
    logic [3:0] q0[$];
    int cnt1 = 0;
    int cnt0 = 0;

    always #5 clk = ~clk;

    pipe_ctrl_stage #(.W(4), .BUBBLE(4'h0), .SKID(1'b1), .CNT_W(4)) dutSkid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady1), .in_data(in_data),
        .out_valid(outValid1), .out_ready(out_ready), .out_data(outData1),
        .stall_cnt(stallCnt1)
    );

    pipe_ctrl_stage #(.W(4), .BUBBLE(4'h0), .SKID(1'b0), .CNT_W(4)) dutDirect (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady0), .in_data(in_data),
        .out_valid(outValid0), .out_ready(out_ready), .out_data(outData0),
        .stall_cnt(stallCnt0)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, compare just after, advance model at posedge.
    task automatic step(input logic rst, input logic fl, input logic iv, input logic [3:0] id,
                        input logic orr);
        bit rdy1, rdy0, pop1, pop0;
        @(negedge clk);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = orr;
        #1;
        if (armed) begin
            checkEq("skid_valid", outValid1, q1.size() > 0);
            checkEq("skid_data", outData1, q1.size() > 0 ? q1[0] : 4'h0);
            checkEq("skid_ready", inReady1, q1.size() < 2);
            checkEq("skid_cnt", stallCnt1, cnt1);
            checkEq("dir_valid", outValid0, q0.size() > 0);
            checkEq("dir_data", outData0, q0.size() > 0 ? q0[0] : 4'h0);
            checkEq("dir_ready", inReady0, q0.size() == 0 || orr);
            checkEq("dir_cnt", stallCnt0, cnt0);
        end
        @(posedge clk);
        rdy1 = q1.size() < 2;
        rdy0 = q0.size() == 0 || orr;
        pop1 = q1.size() > 0 && orr;
        pop0 = q0.size() > 0 && orr;
        if (rst) begin
            q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0; armed = 1'b1;
        end else begin
            if (q1.size() > 0 && !orr && cnt1 < 15) cnt1++;
            if (q0.size() > 0 && !orr && cnt0 < 15) cnt0++;
            if (fl) begin
                q1.delete(); q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (pop0) void'(q0.pop_front());
                if (iv && rdy1) q1.push_back(id);
                if (iv && rdy0) q0.push_back(id);
            end
        end
    endtask

    initial begin
        // Reset held two cycles while upstream presents a word
        step(1, 0, 1, 4'hB, 0);
        step(1, 0, 1, 4'hB, 0);
        #1;
        checkEq("rst_valid", outValid1, 0);
        checkEq("rst_data", outData1, 4'h0);
        checkEq("rst_ready", inReady1, 1);
        checkEq("rst_cnt", stallCnt1, 0);

        // Back-to-back streaming
        step(0, 0, 1, 4'h9, 1); #1; checkEq("stream0", outData1, 4'h9);
        step(0, 0, 1, 4'hA, 1); #1; checkEq("stream1", outData1, 4'hA);
        step(0, 0, 1, 4'hB, 1); #1; checkEq("stream2", outData1, 4'hB);
        checkEq("stream2_dir", outData0, 4'hB);
        step(0, 0, 0, 4'h0, 1);

        // Stall into the skid slot, then release
        step(1, 0, 0, 4'h0, 0);
        step(0, 0, 1, 4'h9, 0);
        step(0, 0, 1, 4'hA, 0); #1; checkEq("skid_full_ready", inReady1, 0);
        step(0, 0, 1, 4'h7, 0); #1; checkEq("stall_cnt2", stallCnt1, 2);
        step(0, 0, 0, 4'h0, 1); #1; checkEq("release_a", outData1, 4'hA);
        step(0, 0, 0, 4'h0, 1); #1; checkEq("release_empty", outValid1, 0);

        // Flush while full, with a word offered in the same cycle
        step(0, 0, 1, 4'h9, 0);
        step(0, 0, 1, 4'hA, 0);
        step(0, 1, 1, 4'hC, 0); #1;
        checkEq("flush_valid", outValid1, 0);
        checkEq("flush_data", outData1, 4'h0);
        step(0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 4'h0, 1);

        // Single-register bypass: consume and accept in one cycle
        step(0, 0, 1, 4'h5, 0);
        step(0, 0, 1, 4'h6, 1); #1; checkEq("bypass_data", outData0, 4'h6);
        step(0, 0, 0, 4'h0, 1);

        // Counter saturation survives flush
        step(1, 0, 0, 4'h0, 0);
        step(0, 0, 1, 4'h9, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 4'h0, 0);
        step(0, 1, 0, 4'h0, 0);
        step(0, 0, 0, 4'h0, 1); #1;
        checkEq("sat_skid", stallCnt1, 15);
        checkEq("sat_dir", stallCnt0, 15);

        // Randomised traffic
        step(1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
